// File: rtl/instruction_issuer_pkg.sv
// Constants shared by the instruction issuer and the datapath: widths, opcodes
// and the issuer state encoding.
package instruction_issuer_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned OPCODE_WIDTH      = 4;
  localparam int unsigned RESULT_WIDTH      = 16;
  localparam int unsigned ADDR_WIDTH        = 16;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_PLOT  = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_READ  = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_WRITE = 4'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } issuer_state_e;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
    input logic [INSTRUCTION_WIDTH-1:0] instr
  );
    return instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

endpackage

// File: rtl/issuer_watchdog.sv
// Cycle counter for the issuer watchdog; expired_o flags the last allowed
// cycle of an operation. Only instantiated when ISSUER_TIMEOUT_EN is defined.
module issuer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: synchronous active-low reset; state updates use non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/instruction_issuer.sv
// Issues host commands to the datapath one at a time and returns read results.
// Define ISSUER_TIMEOUT_EN to add a watchdog that aborts stuck operations.
module instruction_issuer
  import instruction_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] cmd_instruction,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [RESULT_WIDTH-1:0]      rsp_result,
  output logic [ADDR_WIDTH-1:0]        rsp_addr,
  output logic                         dp_start,
  output logic [INSTRUCTION_WIDTH-1:0] dp_instruction,
  input  logic                         dp_finished,
  input  logic [RESULT_WIDTH-1:0]      dp_result,
  output logic                         busy,
  output logic                         timeout_err
);

  issuer_state_e                  state_q;
  logic [INSTRUCTION_WIDTH-1:0]   dp_instruction_q;
  logic                           rsp_valid_q;
  logic [RESULT_WIDTH-1:0]        rsp_result_q;
  logic [ADDR_WIDTH-1:0]          rsp_addr_q;
  logic                           cmd_fire;
  logic                           expired;

  assign cmd_ready      = (state_q == IDLE) && !rsp_valid_q;
  assign cmd_fire       = cmd_valid && cmd_ready;
  assign busy           = (state_q != IDLE);
  // The start strobe follows dp_finished so a busy datapath delays the issue.
  assign dp_start       = (state_q == ISSUE) && dp_finished && !expired;
  assign dp_instruction = dp_instruction_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_addr       = rsp_addr_q;

`ifdef ISSUER_TIMEOUT_EN
  logic timeout_err_q;

  issuer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .resetn   (resetn),
    .clear_i  (cmd_fire),
    .enable_i (busy),
    .expired_o(expired)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      timeout_err_q <= 1'b0;
    end else if (expired) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign expired               = 1'b0;
  assign timeout_err           = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q          <= IDLE;
      dp_instruction_q <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_result_q     <= '0;
      rsp_addr_q       <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      // A watchdog expiry aborts the operation from any busy state, without a response.
      if (expired) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (cmd_fire) begin
              dp_instruction_q <= cmd_instruction;
              state_q          <= ISSUE;
            end
          end
          ISSUE: begin
            if (dp_finished) state_q <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (!dp_finished) state_q <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (dp_finished) begin
              state_q <= IDLE;
              if (opcode_of(dp_instruction_q) == OPCODE_READ) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= dp_result;
                rsp_addr_q   <= dp_instruction_q[ADDR_WIDTH-1:0];
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/instruction_issuer.md
INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, sets the watchdog limit in cycles.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 resetn  in  1  reset; synchronous, active-low.
REQ-004 cmd_valid  in  1  host command present.
REQ-005 cmd_ready  out  1  issuer accepts a command this cycle.
REQ-006 cmd_instruction  in  INSTRUCTION_WIDTH (32)  instruction word; opcode in bits [31:28].
REQ-007 rsp_valid  out  1  read response present.
REQ-008 rsp_ready  in  1  host consumes the response.
REQ-009 rsp_result  out  RESULT_WIDTH (16)  read data.
REQ-010 rsp_addr  out  16  address of the read, equal to instruction[15:0].
REQ-011 dp_start  out  1  start strobe to the datapath.
REQ-012 dp_instruction  out  32  instruction to the datapath.
REQ-013 dp_finished  in  1  datapath idle/done; high after reset.
REQ-014 dp_result  in  16  datapath result.
REQ-015 busy  out  1  high when state != IDLE.
REQ-016 timeout_err  out  1  sticky watchdog error.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_ACK and WAIT_DONE, stored in a registered state machine.
REQ-018 cmd_ready SHALL be 1 only in IDLE with rsp_valid=0; a handshake at edge N latches cmd_instruction into dp_instruction and moves to ISSUE.
REQ-019 ISSUE SHALL drive dp_start = dp_finished; on the first edge with dp_finished=1, move to WAIT_ACK, so that dp_start is high for exactly one cycle.
REQ-020 WAIT_ACK SHALL wait for dp_finished=0, then move to WAIT_DONE; the datapath lowers dp_finished for at least one cycle after the start.
REQ-021 On the first WAIT_DONE edge with dp_finished=1, the issuer SHALL return to IDLE.
- If the opcode is 2 (read), the same edge SHALL capture dp_result into rsp_result and instruction[15:0] into rsp_addr, and set rsp_valid=1.
- All other opcodes SHALL complete with no response.
REQ-022 rsp_valid SHALL hold, with data stable, until an edge with rsp_ready=1, which clears it; the next command is not accepted while rsp_valid=1.
REQ-023 Minimum command-to-command spacing for a non-read opcode SHALL be 4 cycles: accept, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-024 dp_instruction SHALL remain stable from ISSUE until the return to IDLE.
REQ-025 A cmd_valid arriving while busy SHALL be ignored, with no overwrite and no loss.

Reset
REQ-026 While resetn=0 at an edge, all of the following SHALL apply:
- state becomes IDLE;
- dp_start=0, dp_instruction=0, rsp_valid=0, rsp_result=0, rsp_addr=0, timeout_err=0;
- any in-flight command is dropped.
REQ-027 Reset in any state, including mid-operation, SHALL produce no response and no further dp_start.

Configuration
REQ-028 With ISSUER_TIMEOUT_EN defined, the watchdog SHALL behave as follows:
- a cycle counter clears on entry to ISSUE and increments in ISSUE, WAIT_ACK and WAIT_DONE;
- at count TIMEOUT_CYCLES-1 the state is forced to IDLE, timeout_err=1 (sticky until reset), and no response is produced.
REQ-029 Without ISSUER_TIMEOUT_EN, the issuer SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-030 The following SHALL come from the shared constants header used by the datapath:
- INSTRUCTION_WIDTH, OPCODE_WIDTH, RESULT_WIDTH;
- opcode values 1 (plot), 2 (read), 3 (write);
- the state encoding.
REQ-031 The watchdog counter SHALL be the sub-module issuer_watchdog (inputs clear/enable; output expired), instantiated only under ISSUER_TIMEOUT_EN.

Verification
REQ-032 Reset release, dp_finished=1, cmd_valid=0 -> cmd_ready=1, busy=0, dp_start=0, rsp_valid=0.
REQ-033 Read command 0x2000_0040; datapath model drops finished for 2 cycles and returns 0x0ABC -> exactly one dp_start pulse; rsp_valid=1 with rsp_result=0x0ABC and rsp_addr=0x0040; with rsp_ready held 0 for 5 cycles, data is held and cmd_ready=0.
REQ-034 Plot command 0x1004_2A10 followed by a write command 0x3123_0005 -> two single-cycle dp_start pulses carrying the matching instructions, no rsp_valid, and 4-cycle spacing.
REQ-035 dp_finished held 0 at issue time -> dp_start stays 0 in ISSUE until dp_finished=1, then pulses exactly once.
REQ-036 Reset asserted in WAIT_DONE during a read -> after release, state is IDLE and rsp_valid=0; the datapath completing later produces no response.
REQ-037 ISSUER_TIMEOUT_EN with TIMEOUT_CYCLES=16, and the datapath never re-asserting finished -> timeout_err=1 at cycle 16, busy=0, and cmd_ready=1 on the next cycle.
